// File: rtl/block_reorder_merger.sv
`default_nettype none
// ============================================================================
//  Module      : block_reorder_merger
//  Description : Merges out-of-order blocks from several lanes into one
//                in-order stream through a sequence-indexed reorder buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module block_reorder_merger #(
    parameter int BLOCK_WIDTH       = 32,
    parameter int NUM_LANES         = 4,
    parameter int SEQUENCE_ID_WIDTH = 8,
    parameter int ROB_DEPTH         = 16
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [NUM_LANES-1:0][BLOCK_WIDTH-1:0]         lane_data,
    input  logic [NUM_LANES-1:0][SEQUENCE_ID_WIDTH-1:0]   lane_seq_id,
    input  logic [NUM_LANES-1:0]                          lane_valid,
    output logic [NUM_LANES-1:0]                          lane_ready,
    output logic [BLOCK_WIDTH-1:0]                        data_out,
    output logic [SEQUENCE_ID_WIDTH-1:0]                  data_out_seq_id,
    output logic                                          data_out_valid,
    input  logic                                          data_out_ready,
    output logic [$clog2(ROB_DEPTH):0]                    occupancy,
    output logic                                          dup_error
);

    localparam int c_IDX_W = $clog2(ROB_DEPTH);
    localparam int c_OCC_W = c_IDX_W + 1;
    localparam logic [SEQUENCE_ID_WIDTH-1:0] c_WINDOW = SEQUENCE_ID_WIDTH'(ROB_DEPTH);

    logic [SEQUENCE_ID_WIDTH-1:0]  r_exp_seq;
    logic [ROB_DEPTH-1:0]          r_filled;
    logic [BLOCK_WIDTH-1:0]        r_slot_data [ROB_DEPTH];
    logic [BLOCK_WIDTH-1:0]        r_data_out;
    logic [SEQUENCE_ID_WIDTH-1:0]  r_data_out_seq_id;
    logic                          r_data_out_valid;
    logic [c_OCC_W-1:0]            r_occupancy;
    logic                          r_dup_error;

    logic [SEQUENCE_ID_WIDTH-1:0]                  w_exp_seq;
    logic [NUM_LANES-1:0][SEQUENCE_ID_WIDTH-1:0]   w_dist;
    logic [NUM_LANES-1:0][c_IDX_W-1:0]             w_slot_idx;
    logic [NUM_LANES-1:0]                          w_accept;
    logic [NUM_LANES-1:0]                          w_wr_en;
    logic [c_OCC_W-1:0]                            w_wr_cnt;
    logic                                          w_dup;
    logic [c_IDX_W-1:0]                            w_exp_idx;
    logic                                          w_pop;

    // While reset is held the window already reflects the post-reset state.
    assign w_exp_seq = reset ? r_exp_seq : '0;

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            assign w_dist[i]     = lane_seq_id[i] - w_exp_seq;
            assign lane_ready[i] = (w_dist[i] < c_WINDOW);
            assign w_slot_idx[i] = lane_seq_id[i][c_IDX_W-1:0];
            assign w_accept[i]   = lane_valid[i] & lane_ready[i];
        end
    endgenerate

    // Lowest lane index wins when several accepted lanes carry the same ID.
    always_comb begin
        w_wr_en  = '0;
        w_wr_cnt = '0;
        w_dup    = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            logic w_clash;
            w_clash = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (w_accept[j] && (lane_seq_id[j] == lane_seq_id[i])) begin
                    w_clash = 1'b1;
                end
            end
            if (w_accept[i]) begin
                if (r_filled[w_slot_idx[i]] || w_clash) begin
                    w_dup = 1'b1;
                end else begin
                    w_wr_en[i] = 1'b1;
                    w_wr_cnt   = w_wr_cnt + c_OCC_W'(1);
                end
            end
        end
    end

    assign w_exp_idx = r_exp_seq[c_IDX_W-1:0];
    assign w_pop     = r_filled[w_exp_idx] & (~r_data_out_valid | data_out_ready);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_exp_seq         <= '0;
            r_filled          <= '0;
            r_data_out        <= '0;
            r_data_out_seq_id <= '0;
            r_data_out_valid  <= 1'b0;
            r_occupancy       <= '0;
            r_dup_error       <= 1'b0;
        end else begin
            // A pop and a write can never hit the same slot: the window is
            // checked against the pre-edge expected sequence.
            if (w_pop) begin
                r_filled[w_exp_idx] <= 1'b0;
                r_data_out          <= r_slot_data[w_exp_idx];
                r_data_out_seq_id   <= r_exp_seq;
                r_data_out_valid    <= 1'b1;
                r_exp_seq           <= r_exp_seq + 1'b1;
            end else if (data_out_ready) begin
                r_data_out_valid    <= 1'b0;
            end
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_wr_en[i]) begin
                    r_filled[w_slot_idx[i]] <= 1'b1;
                end
            end
            r_occupancy <= r_occupancy + w_wr_cnt - c_OCC_W'(w_pop);
            if (w_dup) begin
                r_dup_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_wr_en[i]) begin
                r_slot_data[w_slot_idx[i]] <= lane_data[i];
            end
        end
    end

    assign data_out        = r_data_out;
    assign data_out_seq_id = r_data_out_seq_id;
    assign data_out_valid  = r_data_out_valid;
    assign occupancy       = r_occupancy;
    assign dup_error       = r_dup_error;

endmodule
`default_nettype wire
